// File: rtl/uk101_video_pkg.sv
// Shared timing defaults, mode encoding and small decode helpers for the UK101 video path.
// LINE_LENGTH is what video_mixer consumes; it tracks the default line total.
package uk101_video_pkg;

  typedef enum logic {
    MODE_64X32 = 1'b0,
    MODE_48X16 = 1'b1
  } video_mode_t;

  localparam int unsigned DEF_CE_DIV       = 32'd6;
  localparam int unsigned DEF_H_TOTAL      = 32'd528;
  localparam int unsigned DEF_H_ACT0       = 32'd512;
  localparam int unsigned DEF_H_ACT1       = 32'd384;
  localparam int unsigned DEF_H_SYNC_START = 32'd448;
  localparam int unsigned DEF_H_SYNC_LEN   = 32'd40;
  localparam int unsigned DEF_V_TOTAL      = 32'd312;
  localparam int unsigned DEF_V_ACT0       = 32'd256;
  localparam int unsigned DEF_V_ACT1       = 32'd256;
  localparam int unsigned DEF_V_SYNC_START = 32'd272;
  localparam int unsigned DEF_V_SYNC_LEN   = 32'd4;
  localparam bit          DEF_SYNC_POL     = 1'b0;
  localparam int unsigned LINE_LENGTH      = DEF_H_TOTAL;
  localparam int unsigned H_SYNC0_OFFSET   = 32'd4;

  // The window end is formed one bit wider so start+len never wraps.
  function automatic logic in_window(input logic [9:0] pos, input logic [9:0] start,
                                     input logic [9:0] len);
    logic [10:0] stop;
    stop = {1'b0, start} + {1'b0, len};
    return (pos >= start) && ({1'b0, pos} < stop);
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/uk101_ce_div.sv
// Free-running divide-by-DIV clock enable with a registered, one-cycle-wide output.
// Also used for the cassette/ACIA baud enable.
module uk101_ce_div #(
  parameter int unsigned DIV = 32'd6
) (
  input  logic clk,
  input  logic reset,
  output logic ce
);

  localparam int unsigned   CW       = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d;

  // Next divider count and enable pulse.
  always_comb begin
    cnt_d = cnt_q;
    ce_d  = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      ce_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      ce_d  = 1'b0;
    end
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/uk101_video_timing.sv
// Raster timing for the UK101 display: pixel enable, counters, blanking, syncs and mode latch.
// Flags are decoded from the next counter value so they line up with pix_x/pix_y.
module uk101_video_timing
  import uk101_video_pkg::*;
#(
  parameter int unsigned CE_DIV       = DEF_CE_DIV,
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned H_ACT0       = DEF_H_ACT0,
  parameter int unsigned H_ACT1       = DEF_H_ACT1,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned V_ACT0       = DEF_V_ACT0,
  parameter int unsigned V_ACT1       = DEF_V_ACT1,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN,
  parameter bit          SYNC_POL     = DEF_SYNC_POL
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       mode_sel,
  output logic       ce_pix,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       frame_start,
  output logic       mode_act
);

  if (CE_DIV < 32'd2) begin : g_bad_div
    $error("uk101_video_timing: CE_DIV must be at least 2");
  end
  if ((H_ACT0 > H_TOTAL) || (H_ACT1 > H_TOTAL) || (H_SYNC_START + H_SYNC_LEN > H_TOTAL)) begin : g_bad_h
    $error("uk101_video_timing: horizontal timing exceeds H_TOTAL");
  end
  if ((V_ACT0 > V_TOTAL) || (V_ACT1 > V_TOTAL) || (V_SYNC_START + V_SYNC_LEN > V_TOTAL)) begin : g_bad_v
    $error("uk101_video_timing: vertical timing exceeds V_TOTAL");
  end

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 32'd1);
  localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 32'd1);
  localparam logic [9:0] H_ACT0_W = 10'(H_ACT0);
  localparam logic [9:0] H_ACT1_W = 10'(H_ACT1);
  localparam logic [9:0] HS0_W    = 10'(H_ACT0 + H_SYNC0_OFFSET);
  localparam logic [9:0] HS1_W    = 10'(H_SYNC_START);
  localparam logic [9:0] HSL_W    = 10'(H_SYNC_LEN);
  localparam logic [9:0] V_ACT0_W = 10'(V_ACT0);
  localparam logic [9:0] V_ACT1_W = 10'(V_ACT1);
  localparam logic [9:0] VS_W     = 10'(V_SYNC_START);
  localparam logic [9:0] VSL_W    = 10'(V_SYNC_LEN);

  logic        ce_s;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  video_mode_t mode_q, mode_d;
  logic        hblank_q, hblank_d, vblank_q, vblank_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        fs_q, fs_d;
  logic        line_end, frame_wrap, wide_mode;

  uk101_ce_div #(.DIV(CE_DIV)) u_ce_div (
    .clk   (clk_sys),
    .reset (reset),
    .ce    (ce_s)
  );

  // Counter advance and flag decode; everything holds between pixel enables.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    mode_d     = mode_q;
    hblank_d   = hblank_q;
    vblank_d   = vblank_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    fs_d       = fs_q;
    line_end   = (x_q == H_LAST);
    frame_wrap = line_end && (y_q == V_LAST);
    wide_mode  = 1'b0;
    if (ce_s) begin
      if (line_end) begin
        x_d = 10'd0;
        y_d = (y_q == V_LAST) ? 9'd0 : (y_q + 9'd1);
      end else begin
        x_d = x_q + 10'd1;
        y_d = y_q;
      end
      mode_d    = frame_wrap ? video_mode_t'(mode_sel) : mode_q;
      fs_d      = frame_wrap;
      wide_mode = (mode_d == MODE_48X16);
      hblank_d  = x_d >= (wide_mode ? H_ACT1_W : H_ACT0_W);
      vblank_d  = {1'b0, y_d} >= (wide_mode ? V_ACT1_W : V_ACT0_W);
      hsync_d   = sync_level(in_window(x_d, wide_mode ? HS1_W : HS0_W, HSL_W), SYNC_POL);
      vsync_d   = sync_level(in_window({1'b0, y_d}, VS_W, VSL_W), SYNC_POL);
    end else begin
      fs_d = fs_q;
    end
  end

  // Raster state register; reset overrides any coincident pixel enable.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      x_q      <= 10'd0;
      y_q      <= 9'd0;
      mode_q   <= MODE_64X32;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      fs_q     <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
    end
  end

  assign ce_pix      = ce_s;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign mode_act    = mode_q;

endmodule

// File: tb/tb_uk101_video_timing.sv
// Scoreboarded bench for uk101_video_timing: three instances with different timing sets,
// each stepped against a behavioural raster model.
module tb_uk101_video_timing;

  typedef struct packed {
    logic       ce;
    logic [9:0] x;
    logic [8:0] y;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       mode;
  } exp_t;

  localparam int P_CE  [3] = '{6, 2, 2};
  localparam int P_HT  [3] = '{600, 400, 8};
  localparam int P_HA0 [3] = '{512, 320, 6};
  localparam int P_HA1 [3] = '{384, 384, 4};
  localparam int P_HSS [3] = '{448, 390, 5};
  localparam int P_HSL [3] = '{40, 8, 2};
  localparam int P_VT  [3] = '{312, 16, 4};
  localparam int P_VA0 [3] = '{256, 12, 3};
  localparam int P_VA1 [3] = '{256, 10, 2};
  localparam int P_VSS [3] = '{272, 13, 3};
  localparam int P_VSL [3] = '{4, 2, 1};
  localparam int P_POL [3] = '{0, 0, 1};

  logic clk;
  logic rst_a, rst_b, rst_c, msel_a, msel_b, msel_c;
  logic ce_a, hs_a, vs_a, hb_a, vb_a, fs_a, mode_a;
  logic ce_b, hs_b, vs_b, hb_b, vb_b, fs_b, mode_b;
  logic ce_c, hs_c, vs_c, hb_c, vb_c, fs_c, mode_c;
  logic [9:0] x_a, x_b, x_c;
  logic [8:0] y_a, y_b, y_c;

  exp_t ms [3];
  int   dv [3];
  exp_t sbq [$];
  int   n_pass = 0;
  int   n_total = 0;

  uk101_video_timing #(
    .CE_DIV(P_CE[0]), .H_TOTAL(P_HT[0]), .H_ACT0(P_HA0[0]), .H_ACT1(P_HA1[0]),
    .H_SYNC_START(P_HSS[0]), .H_SYNC_LEN(P_HSL[0]), .V_TOTAL(P_VT[0]), .V_ACT0(P_VA0[0]),
    .V_ACT1(P_VA1[0]), .V_SYNC_START(P_VSS[0]), .V_SYNC_LEN(P_VSL[0]), .SYNC_POL(P_POL[0] != 0)
  ) dut_a (
    .clk_sys(clk), .reset(rst_a), .mode_sel(msel_a), .ce_pix(ce_a), .hsync(hs_a), .vsync(vs_a),
    .hblank(hb_a), .vblank(vb_a), .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a), .mode_act(mode_a)
  );

  uk101_video_timing #(
    .CE_DIV(P_CE[1]), .H_TOTAL(P_HT[1]), .H_ACT0(P_HA0[1]), .H_ACT1(P_HA1[1]),
    .H_SYNC_START(P_HSS[1]), .H_SYNC_LEN(P_HSL[1]), .V_TOTAL(P_VT[1]), .V_ACT0(P_VA0[1]),
    .V_ACT1(P_VA1[1]), .V_SYNC_START(P_VSS[1]), .V_SYNC_LEN(P_VSL[1]), .SYNC_POL(P_POL[1] != 0)
  ) dut_b (
    .clk_sys(clk), .reset(rst_b), .mode_sel(msel_b), .ce_pix(ce_b), .hsync(hs_b), .vsync(vs_b),
    .hblank(hb_b), .vblank(vb_b), .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b), .mode_act(mode_b)
  );

  uk101_video_timing #(
    .CE_DIV(P_CE[2]), .H_TOTAL(P_HT[2]), .H_ACT0(P_HA0[2]), .H_ACT1(P_HA1[2]),
    .H_SYNC_START(P_HSS[2]), .H_SYNC_LEN(P_HSL[2]), .V_TOTAL(P_VT[2]), .V_ACT0(P_VA0[2]),
    .V_ACT1(P_VA1[2]), .V_SYNC_START(P_VSS[2]), .V_SYNC_LEN(P_VSL[2]), .SYNC_POL(P_POL[2] != 0)
  ) dut_c (
    .clk_sys(clk), .reset(rst_c), .mode_sel(msel_c), .ce_pix(ce_c), .hsync(hs_c), .vsync(vs_c),
    .hblank(hb_c), .vblank(vb_c), .pix_x(x_c), .pix_y(y_c), .frame_start(fs_c), .mode_act(mode_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string fmt(input exp_t s);
    return $sformatf("ce=%b x=%0d y=%0d hb=%b vb=%b hs=%b vs=%b fs=%b mode=%b",
                     s.ce, s.x, s.y, s.hb, s.vb, s.hs, s.vs, s.fs, s.mode);
  endfunction

  function automatic exp_t reset_state(input int i);
    exp_t s;
    logic pol;
    pol = (P_POL[i] != 0);
    s = '0;
    s.hs = !pol;
    s.vs = !pol;
    return s;
  endfunction

  function automatic exp_t sample(input int i);
    exp_t s;
    case (i)
      0:       s = {ce_a, x_a, y_a, hb_a, vb_a, hs_a, vs_a, fs_a, mode_a};
      1:       s = {ce_b, x_b, y_b, hb_b, vb_b, hs_b, vs_b, fs_b, mode_b};
      default: s = {ce_c, x_c, y_c, hb_c, vb_c, hs_c, vs_c, fs_c, mode_c};
    endcase
    return s;
  endfunction

  // Reference raster: one pixel step for instance i.
  function automatic exp_t adv(input exp_t s, input logic msel, input int i);
    exp_t n;
    logic wrap, pol;
    int   ha, hss, va;
    n    = s;
    pol  = (P_POL[i] != 0);
    wrap = (int'(s.x) == P_HT[i] - 1) && (int'(s.y) == P_VT[i] - 1);
    if (int'(s.x) == P_HT[i] - 1) begin
      n.x = 10'd0;
      n.y = (int'(s.y) == P_VT[i] - 1) ? 9'd0 : s.y + 9'd1;
    end else begin
      n.x = s.x + 10'd1;
    end
    n.mode = wrap ? msel : s.mode;
    n.fs   = wrap;
    ha     = n.mode ? P_HA1[i] : P_HA0[i];
    hss    = n.mode ? P_HSS[i] : P_HA0[i] + 4;
    va     = n.mode ? P_VA1[i] : P_VA0[i];
    n.hb   = int'(n.x) >= ha;
    n.vb   = int'(n.y) >= va;
    n.hs   = ((int'(n.x) >= hss) && (int'(n.x) < hss + P_HSL[i])) ? pol : !pol;
    n.vs   = ((int'(n.y) >= P_VSS[i]) && (int'(n.y) < P_VSS[i] + P_VSL[i])) ? pol : !pol;
    return n;
  endfunction

  // Advance model for one clk_sys, queue the expectation, then let the DUT take the edge.
  task automatic step(input int i);
    logic r, m;
    exp_t e;
    case (i)
      0:       begin r = rst_a; m = msel_a; end
      1:       begin r = rst_b; m = msel_b; end
      default: begin r = rst_c; m = msel_c; end
    endcase
    if (r) begin
      ms[i] = reset_state(i);
      dv[i] = 0;
    end else begin
      e = ms[i];
      if (e.ce) e = adv(e, m, i);
      e.ce  = (dv[i] == P_CE[i] - 1);
      dv[i] = (dv[i] == P_CE[i] - 1) ? 0 : dv[i] + 1;
      ms[i] = e;
    end
    sbq.push_back(ms[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t got, exp;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    msel_a = 1'b0; msel_b = 1'b0; msel_c = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(0);
      got = sample(0); exp = sbq.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL reset_a: actual %s required %s", fmt(got), fmt(exp));
      else n_pass++;
    end
    n_total++;
    if ({hs_a, vs_a, ce_a, fs_a} !== 4'b1100) $display("FAIL reset_sync_a: actual %b required 1100", {hs_a, vs_a, ce_a, fs_a});
    else n_pass++;
    got = sample(2); exp = reset_state(2);
    n_total++;
    if (got !== exp) $display("FAIL reset_c_pol: actual %s required %s", fmt(got), fmt(exp));
    else n_pass++;
  endtask

  task automatic test_ce_div();
    exp_t got, exp;
    int pulses = 0;
    rst_a = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step(0);
      got = sample(0); exp = sbq.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL ce_model clk %0d: actual %s required %s", n, fmt(got), fmt(exp));
      else n_pass++;
      n_total++;
      if (ce_a !== ((n % 6) == 0)) $display("FAIL ce_phase clk %0d: actual %b required %b", n, ce_a, (n % 6) == 0);
      else n_pass++;
      if (ce_a === 1'b1) pulses++;
    end
    n_total++;
    if (pulses != 5) $display("FAIL ce_count: actual %0d required 5", pulses);
    else n_pass++;
  endtask

  task automatic test_line_mode0();
    exp_t got, exp;
    int   hb_rise = -1, hs_fall = -1, hs_rise = -1;
    bit   done = 1'b0, wrapped = 1'b0;
    logic hb_prev, hs_prev;
    logic [9:0] x_prev;
    hb_prev = hb_a; hs_prev = hs_a; x_prev = x_a;
    for (int k = 0; k < 6000 && !done; k++) begin
      step(0);
      got = sample(0); exp = sbq.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL line_a: actual %s required %s", fmt(got), fmt(exp));
      else n_pass++;
      if (hb_rise < 0 && hb_prev === 1'b0 && hb_a === 1'b1) hb_rise = int'(x_a);
      if (hs_fall < 0 && hs_prev === 1'b1 && hs_a === 1'b0) hs_fall = int'(x_a);
      if (hs_fall >= 0 && hs_rise < 0 && hs_prev === 1'b0 && hs_a === 1'b1) hs_rise = int'(x_a);
      if (!wrapped && x_prev === 10'd599 && x_a === 10'd0) begin
        wrapped = 1'b1;
        n_total++;
        if (y_a !== 9'd1) $display("FAIL line_wrap_y: actual %0d required 1", y_a);
        else n_pass++;
      end
      hb_prev = hb_a; hs_prev = hs_a; x_prev = x_a;
      done = (ms[0].y == 9'd1) && (ms[0].x == 10'd8);
    end
    n_total++;
    if (!done || !wrapped) $display("FAIL line_timeout: actual done=%b wrapped=%b required 1 1", done, wrapped);
    else n_pass++;
    n_total++;
    if (hb_rise != 512) $display("FAIL hblank_rise_m0: actual %0d required 512", hb_rise);
    else n_pass++;
    n_total++;
    if (hs_fall != 516 || hs_rise != 556) $display("FAIL hsync_window_m0: actual %0d..%0d required 516..556", hs_fall, hs_rise);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t got, exp;
    bit at = 1'b0;
    int first = -1;
    for (int k = 0; k < 6000 && !at; k++) begin
      step(0);
      got = sample(0); exp = sbq.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL pre_reset_a: actual %s required %s", fmt(got), fmt(exp));
      else n_pass++;
      at = (ms[0].x == 10'd300) && (ms[0].y == 9'd1) && (dv[0] == 3);
    end
    n_total++;
    if (!at) $display("FAIL reset_mid_timeout: actual 0 required 1");
    else n_pass++;
    rst_a = 1'b1;
    step(0);
    got = sample(0); exp = sbq.pop_front();
    n_total++;
    if (got !== exp) $display("FAIL reset_mid_a: actual %s required %s", fmt(got), fmt(exp));
    else n_pass++;
    n_total++;
    if ({ce_a, x_a, y_a, hs_a, vs_a} !== {1'b0, 10'd0, 9'd0, 1'b1, 1'b1})
      $display("FAIL reset_mid_vals: actual x=%0d y=%0d ce=%b required x=0 y=0 ce=0", x_a, y_a, ce_a);
    else n_pass++;
    rst_a = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step(0);
      got = sample(0); exp = sbq.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL post_reset_a: actual %s required %s", fmt(got), fmt(exp));
      else n_pass++;
      if (first < 0 && ce_a === 1'b1) first = n;
    end
    n_total++;
    if (first != 6) $display("FAIL reset_first_ce: actual %0d required 6", first);
    else n_pass++;
  endtask

  task automatic test_frame_small();
    exp_t got, exp;
    int   rises = 0, ce_between = 0, first_len = -1;
    logic fs_prev = 1'b0;
    rst_c = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      step(2);
      got = sample(2); exp = sbq.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL frame_c: actual %s required %s", fmt(got), fmt(exp));
      else n_pass++;
      if (fs_c === 1'b1 && fs_prev === 1'b0) begin
        rises++;
        if (rises == 2) first_len = ce_between;
        ce_between = 0;
        n_total++;
        if ({x_c, y_c, vb_c, hs_c} !== {10'd0, 9'd0, 1'b0, 1'b0}) $display("FAIL frame_origin_c: actual x=%0d y=%0d vb=%b hs=%b required 0 0 0 0", x_c, y_c, vb_c, hs_c);
        else n_pass++;
      end
      if (ce_c === 1'b1) ce_between++;
      fs_prev = fs_c;
    end
    n_total++;
    if (rises != 3) $display("FAIL frame_count_c: actual %0d required 3", rises);
    else n_pass++;
    n_total++;
    if (first_len != 32) $display("FAIL frame_len_c: actual %0d required 32", first_len);
    else n_pass++;
  endtask

  task automatic test_mode_pulse();
    exp_t got, exp;
    bit   done = 1'b0, seen_wrap = 1'b0, changed = 1'b0;
    int   hb_rise = -1;
    logic hb_prev;
    rst_b = 1'b0; msel_b = 1'b0;
    hb_prev = hb_b;
    for (int k = 0; k < 20000 && !done; k++) begin
      step(1);
      got = sample(1); exp = sbq.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL pulse_b: actual %s required %s", fmt(got), fmt(exp));
      else n_pass++;
      if (mode_b !== 1'b0) changed = 1'b1;
      if (hb_rise < 0 && hb_prev === 1'b0 && hb_b === 1'b1) hb_rise = int'(x_b);
      hb_prev = hb_b;
      if (ms[1].x == 10'd100 && ms[1].y == 9'd5) msel_b = 1'b1;
      if (ms[1].x == 10'd100 && ms[1].y == 9'd10) msel_b = 1'b0;
      if (ms[1].fs) seen_wrap = 1'b1;
      done = seen_wrap && (ms[1].x == 10'd10);
    end
    n_total++;
    if (!done) $display("FAIL pulse_timeout: actual 0 required 1");
    else n_pass++;
    n_total++;
    if (changed) $display("FAIL pulse_mode_kept: actual changed=1 required 0");
    else n_pass++;
    n_total++;
    if (hb_rise != 320) $display("FAIL hblank_rise_b_m0: actual %0d required 320", hb_rise);
    else n_pass++;
  endtask

  task automatic test_mode_switch();
    exp_t got, exp;
    bit   done = 1'b0, sw = 1'b0;
    int   hb_rise = -1;
    logic hb_prev, mode_prev;
    hb_prev = hb_b; mode_prev = mode_b;
    for (int k = 0; k < 20000 && !done; k++) begin
      step(1);
      got = sample(1); exp = sbq.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL switch_b: actual %s required %s", fmt(got), fmt(exp));
      else n_pass++;
      if (ms[1].x == 10'd100 && ms[1].y == 9'd10) msel_b = 1'b1;
      if (!sw && mode_prev === 1'b0 && mode_b === 1'b1) begin
        sw = 1'b1;
        n_total++;
        if ({x_b, y_b, fs_b} !== {10'd0, 9'd0, 1'b1}) $display("FAIL switch_at_origin: actual x=%0d y=%0d fs=%b required 0 0 1", x_b, y_b, fs_b);
        else n_pass++;
      end
      if (sw && hb_rise < 0 && hb_prev === 1'b0 && hb_b === 1'b1) hb_rise = int'(x_b);
      hb_prev = hb_b; mode_prev = mode_b;
      done = sw && ms[1].mode && (ms[1].x == 10'd390);
    end
    n_total++;
    if (!done || !sw) $display("FAIL switch_timeout: actual done=%b sw=%b required 1 1", done, sw);
    else n_pass++;
    n_total++;
    if (hb_rise != 384) $display("FAIL hblank_rise_m1: actual %0d required 384", hb_rise);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ms[i] = reset_state(i);
      dv[i] = 0;
    end
    test_reset();
    test_ce_div();
    test_line_mode0();
    test_reset_mid();
    test_frame_small();
    test_mode_pulse();
    test_mode_switch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "simulation time limit");
  end

endmodule
